matrix_alu_2x2_seq: RTL and testbench

//   Sequential, parametrised 2x2 matrix ALU: add, sub, multiply, transpose and determinant

---
 rtl/matrix_alu_2x2_seq_if.sv | 40 ++++
 rtl/matrix_alu_2x2_seq.sv | 179 +++++++++++++++++
 tb/tb_matrix_alu_2x2_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/matrix_alu_2x2_seq_if.sv
// rtl/matrix_alu_2x2_seq_if.sv - request/result bundle for the 2x2 matrix ALU
//
// Purpose: groups the start/op/operand request and the busy/done/result
//          response of matrix_alu_2x2_seq into one interface.
// Signals:
//   start     request strobe, sampled by the ALU only while idle
//   op        3-bit opcode (000 add, 001 sub, 010 mul, 011 transpose, 100 det)
//   A, B      4*W operand matrices {x11,x12,x21,x22}, x11 in the MSBs, unsigned
//   busy      high from the cycle after acceptance through the done cycle
//   done      one-cycle completion pulse
//   C         4*RW result matrix {c11,c12,c21,c22}, signed elements
//   singular  determinant result was zero
//   err       opcode was not one of the five legal values
// Modports: master drives the request, slave (the ALU) drives the response.

interface matrix_alu_2x2_seq_if #(
  parameter int W = 4
);
  localparam int RW = 2 * W + 2;

  logic            start;
  logic [2:0]      op;
  logic [4*W-1:0]  A;
  logic [4*W-1:0]  B;
  logic            busy;
  logic            done;
  logic [4*RW-1:0] C;
  logic            singular;
  logic            err;

  modport master (
    output start, op, A, B,
    input  busy, done, C, singular, err
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, C, singular, err
  );
endinterface

// File: rtl/matrix_alu_2x2_seq.sv
// rtl/matrix_alu_2x2_seq.sv - sequential 2x2 matrix ALU with one shared multiplier
//
// Purpose: add, subtract, multiply, transpose and determinant of 2x2 matrices
//          with unsigned W-bit elements, behind a start/done handshake.
//          Multiply and determinant reuse a single W x W multiplier, one
//          product per cycle (8 cycles for mul, 2 for det).
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; aborts any operation in flight
//   bus   matrix_alu_2x2_seq_if slave: start/op/A/B in, busy/done/C/singular/err out
// Latency start->done: add/sub/transpose/illegal 2, det 3, mul 9 cycles.

module matrix_alu_2x2_seq #(
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  matrix_alu_2x2_seq_if.slave  bus
);
  localparam int RW = 2 * W + 2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_TR  = 3'b011;
  localparam logic [2:0] OP_DET = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Element index 3 is x11 (MSBs), 2 is x12, 1 is x21, 0 is x22.
  logic [3:0][W-1:0]  a_q, b_q;
  logic [2:0]         op_q;
  logic [2:0]         cnt;
  logic [3:0][RW-1:0] acc, acc_nxt;
  logic [3:0][RW-1:0] res;
  logic [3:0][RW-1:0] c_q;
  logic               singular_q, err_q;

  logic               last_step;
  logic [1:0]         a_idx, b_idx, acc_idx;
  logic [W-1:0]       mul_x, mul_y;
  logic [2*W-1:0]     prod;
  logic [RW-1:0]      prod_ext;
  logic               singular_nxt, err_nxt;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = EXEC;
      EXEC:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // EXEC length: 8 products for mul, 2 for det, a single cycle otherwise.
  always_comb begin
    case (op_q)
      OP_MUL:  last_step = (cnt == 3'd7);
      OP_DET:  last_step = (cnt == 3'd1);
      default: last_step = (cnt == 3'd0);
    endcase
  end

  // Mul schedule: step i multiplies a[i2][i0] by b[i0][i1] into c[i2][i1],
  // so each accumulator receives two consecutive products.
  // Element (r,c) lives at packed index 3-(2r+c), i.e. the inverted {r,c}.
  always_comb begin
    a_idx   = ~{cnt[2], cnt[0]};
    b_idx   = ~{cnt[0], cnt[1]};
    acc_idx = ~cnt[2:1];
    mul_x   = '0;
    mul_y   = '0;
    if (op_q == OP_DET) begin
      // step0: a11*a22, step1: a12*a21
      mul_x = cnt[0] ? a_q[2] : a_q[3];
      mul_y = cnt[0] ? a_q[1] : a_q[0];
    end else if (op_q == OP_MUL) begin
      mul_x = a_q[a_idx];
      mul_y = b_q[b_idx];
    end
  end

  assign prod     = {{W{1'b0}}, mul_x} * {{W{1'b0}}, mul_y};
  assign prod_ext = {{(RW-2*W){1'b0}}, prod};

  always_comb begin
    acc_nxt = acc;
    if (op_q == OP_DET) begin
      acc_nxt[3] = cnt[0] ? (acc[3] - prod_ext) : (acc[3] + prod_ext);
    end else if (op_q == OP_MUL) begin
      acc_nxt[acc_idx] = acc[acc_idx] + prod_ext;
    end
  end

  // Result as it will appear in the DONE cycle; only captured on the last step.
  always_comb begin
    res = '0;
    case (op_q)
      OP_ADD: begin
        for (int i = 0; i < 4; i++) begin
          res[i] = {{(RW-W){1'b0}}, a_q[i]} + {{(RW-W){1'b0}}, b_q[i]};
        end
      end
      OP_SUB: begin
        for (int i = 0; i < 4; i++) begin
          res[i] = {{(RW-W){1'b0}}, a_q[i]} - {{(RW-W){1'b0}}, b_q[i]};
        end
      end
      OP_MUL, OP_DET: res = acc_nxt;
      OP_TR: begin
        res[3] = {{(RW-W){1'b0}}, a_q[3]};
        res[2] = {{(RW-W){1'b0}}, a_q[1]};
        res[1] = {{(RW-W){1'b0}}, a_q[2]};
        res[0] = {{(RW-W){1'b0}}, a_q[0]};
      end
      default: res = '0;
    endcase
    singular_nxt = (op_q == OP_DET) && (acc_nxt[3] == '0);
    err_nxt      = (op_q > OP_DET);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cnt        <= '0;
      acc        <= '0;
      c_q        <= '0;
      singular_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        a_q  <= bus.A;
        b_q  <= bus.B;
        op_q <= bus.op;
        cnt  <= '0;
        acc  <= '0;
      end
      if (state == EXEC) begin
        cnt <= cnt + 3'd1;
        acc <= acc_nxt;
        if (last_step) begin
          c_q        <= res;
          singular_q <= singular_nxt;
          err_q      <= err_nxt;
        end
      end
    end
  end

  assign bus.C        = c_q;
  assign bus.singular = singular_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_matrix_alu_2x2_seq.sv
// tb/tb_matrix_alu_2x2_seq.sv - directed self-checking bench for matrix_alu_2x2_seq

module tb_matrix_alu_2x2_seq;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  matrix_alu_2x2_seq_if #(.W(4)) bus ();

  matrix_alu_2x2_seq #(.W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] pk(input int c11, input int c12, input int c21, input int c22);
    return {c11[9:0], c12[9:0], c21[9:0], c22[9:0]};
  endfunction

  // Start in cycle N, then check busy/done each cycle up to N+lat and the
  // results in the done cycle; operands are disturbed after acceptance.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b, input int lat, input logic [39:0] ec,
                       input logic es, input logic ee);
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      step();
      if (c == 1) begin
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.op    = o ^ 3'b001;
      end
      chk({tag, "_busy"}, 64'(bus.busy), 64'(1'b1));
      chk({tag, "_done"}, 64'(bus.done), 64'(c == lat));
      if (c == lat) begin
        chk({tag, "_C"}, 64'(bus.C), 64'(ec));
        chk({tag, "_singular"}, 64'(bus.singular), 64'(es));
        chk({tag, "_err"}, 64'(bus.err), 64'(ee));
      end
    end
    step();
    chk({tag, "_idle_busy"}, 64'(bus.busy), 64'(1'b0));
    chk({tag, "_idle_done"}, 64'(bus.done), 64'(1'b0));
    chk({tag, "_hold_C"}, 64'(bus.C), 64'(ec));
  endtask

  initial begin
    logic saw_done;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.A     = '0;
    bus.B     = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_busy", 64'(bus.busy), 64'(1'b0));
    chk("rst_done", 64'(bus.done), 64'(1'b0));
    chk("rst_C", 64'(bus.C), 64'(0));
    chk("rst_singular", 64'(bus.singular), 64'(1'b0));
    chk("rst_err", 64'(bus.err), 64'(1'b0));

    do_op("add", 3'b000, 16'h3214, 16'h1111, 2, pk(4, 3, 2, 5), 1'b0, 1'b0);
    do_op("sub", 3'b001, 16'h1023, 16'h2011, 2, pk(-1, 0, 1, 2), 1'b0, 1'b0);
    chk("sub_c11_raw", 64'(bus.C[39:30]), 64'(10'h3FF));
    do_op("mul", 3'b010, 16'h3214, 16'h1111, 9, pk(5, 5, 5, 5), 1'b0, 1'b0);
    do_op("mul_max", 3'b010, 16'hFFFF, 16'hFFFF, 9, pk(450, 450, 450, 450), 1'b0, 1'b0);
    do_op("det", 3'b100, 16'h1234, 16'h0000, 3, pk(-2, 0, 0, 0), 1'b0, 1'b0);
    do_op("det_sing", 3'b100, 16'h2412, 16'hFFFF, 3, pk(0, 0, 0, 0), 1'b1, 1'b0);
    do_op("tr", 3'b011, 16'h3214, 16'h5555, 2, pk(3, 1, 2, 4), 1'b0, 1'b0);
    do_op("det_neg_max", 3'b100, 16'h0FF0, 16'h0000, 3, pk(-225, 0, 0, 0), 1'b0, 1'b0);
    do_op("illegal", 3'b110, 16'h3214, 16'h1111, 2, pk(0, 0, 0, 0), 1'b0, 1'b1);

    // start held high for the whole mul, including the DONE cycle
    bus.op    = 3'b010;
    bus.A     = 16'h3214;
    bus.B     = 16'h1111;
    bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("hold_start_busy", 64'(bus.busy), 64'(c <= 9));
      chk("hold_start_done", 64'(bus.done), 64'(c == 9));
      if (c == 9) begin
        chk("hold_start_C", 64'(bus.C), 64'(pk(5, 5, 5, 5)));
        chk("hold_start_err", 64'(bus.err), 64'(1'b0));
      end
    end
    bus.start = 1'b0;

    // reset in the middle of a mul
    bus.A     = 16'hFFFF;
    bus.B     = 16'hFFFF;
    bus.start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) bus.start = 1'b0;
    end
    rst = 1'b1;
    step();
    chk("abort_busy", 64'(bus.busy), 64'(1'b0));
    chk("abort_done", 64'(bus.done), 64'(1'b0));
    chk("abort_C", 64'(bus.C), 64'(0));
    chk("abort_singular", 64'(bus.singular), 64'(1'b0));
    chk("abort_err", 64'(bus.err), 64'(1'b0));
    rst      = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'(1'b0));

    // normal operation resumes after the abort
    do_op("post_rst_add", 3'b000, 16'hF0F0, 16'hF0F0, 2, pk(30, 0, 30, 0), 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
